// File: rtl/turbo_itl_ctrl.sv
// turbo_itl_ctrl -- turbo-code interleaver block controller.
// A block of N words is written to an external RAM in natural order. It is then
// read back in the order given by an external interleaver ROM, and streamed out
// through a 4-entry output FIFO.
// Optional build macro: TURBO_ITL_RANGE_CHK_EN. When it is defined, ROM
// addresses >= N are replaced by 0 and flagged on err.
module turbo_itl_ctrl #(
    parameter int D_WIDTH = 13,
    parameter int A_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] blk_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_last,
    output logic [A_WIDTH-1:0] rom_addr,
    input  logic [A_WIDTH-1:0] rom_data,
    output logic               ram_wen,
    output logic [A_WIDTH-1:0] ram_waddr,
    output logic [D_WIDTH-1:0] ram_wdata,
    output logic [A_WIDTH-1:0] ram_raddr,
    input  logic [D_WIDTH-1:0] ram_rdata,
    output logic               busy,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    localparam logic [A_WIDTH-1:0] ONE = 1;

    state_t             state;
    logic [A_WIDTH-1:0] n_len;
    logic [A_WIDTH-1:0] wcnt;
    logic [A_WIDTH-1:0] rcnt;
    logic [A_WIDTH-1:0] ocnt;
    logic               rd_s1;
    logic               rd_s2;
    logic               err_q;

    logic [D_WIDTH-1:0] fifo_mem [4];
    logic [1:0]         wr_ptr;
    logic [1:0]         rd_ptr;
    logic [2:0]         fifo_cnt;

    logic               wr_fire;
    logic               can_issue;
    logic               push;
    logic               pop;
    logic               range_fault;
    logic [A_WIDTH-1:0] raddr_sel;
    logic               last_word;
    logic [2:0]         committed;

    // Handshake decode, issue credit and ROM-to-RAM address path.
    always_comb begin
        wr_fire   = (state == WRITE) && in_valid;
        committed = fifo_cnt + {2'b00, rd_s1} + {2'b00, rd_s2};
        can_issue = (state == READ) && (committed < 3'd4);
        push      = rd_s2;
        pop       = (fifo_cnt != 3'd0) && out_ready;
        last_word = (ocnt == n_len - ONE);
`ifdef TURBO_ITL_RANGE_CHK_EN
        range_fault = rd_s1 && (rom_data >= n_len);
        raddr_sel   = range_fault ? '0 : rom_data;
`else
        range_fault = 1'b0;
        raddr_sel   = rom_data;
`endif
    end

    // Output port decode; data paths are masked to zero whenever they are idle.
    always_comb begin
        in_ready  = (state == WRITE);
        ram_wen   = wr_fire;
        ram_waddr = (state == WRITE) ? wcnt : '0;
        ram_wdata = wr_fire ? in_data : '0;
        rom_addr  = (state == READ) ? rcnt : '0;
        ram_raddr = rd_s1 ? raddr_sel : '0;
        out_valid = (fifo_cnt != 3'd0);
        out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
        out_last  = out_valid && last_word;
        busy      = (state != IDLE);
        err       = err_q;
    end

    // Block FSM, counters, read pipeline valid flags and err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            n_len <= '0;
            wcnt  <= '0;
            rcnt  <= '0;
            ocnt  <= '0;
            rd_s1 <= 1'b0;
            rd_s2 <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= range_fault;
            rd_s1 <= can_issue;
            rd_s2 <= rd_s1;
            if (pop) begin
                ocnt <= ocnt + ONE;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (blk_len != '0) begin
                            n_len <= blk_len;
                            wcnt  <= '0;
                            rcnt  <= '0;
                            ocnt  <= '0;
                            state <= WRITE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        wcnt <= wcnt + ONE;
                        if (wcnt == n_len - ONE) begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (can_issue) begin
                        rcnt <= rcnt + ONE;
                        if (rcnt == n_len - ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && last_word) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output FIFO: RAM read data enters two cycles after issue; the head pops on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= ram_rdata;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_turbo_itl_ctrl.sv
// tb_turbo_itl_ctrl -- directed bench for turbo_itl_ctrl with ROM and RAM models.
module tb_turbo_itl_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] blk_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [12:0] out_data;
    logic        out_last;
    logic [15:0] rom_addr;
    logic [15:0] rom_data = '0;
    logic        ram_wen;
    logic [15:0] ram_waddr;
    logic [12:0] ram_wdata;
    logic [15:0] ram_raddr;
    logic [12:0] ram_rdata = '0;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;
    int rom_mode = 0;
    int cyc = 0;
    int errcnt = 0;
    int busycnt = 0;
    logic [13:0] outq[$];
    int outcyc[$];
    logic [12:0] words[8];
    logic [12:0] ram_mem[256];

    turbo_itl_ctrl #(.D_WIDTH(13), .A_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .blk_len(blk_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] romFn(input int mode, input logic [15:0] a);
        if (mode == 1) return 16'd7 - a;
        if (mode == 2) return (a == 16'd3) ? 16'd9 : 16'd7 - a;
        return a;
    endfunction

    // Registered interleaver ROM and RAM with one-cycle read latency.
    always @(posedge clk) begin
        rom_data  <= romFn(rom_mode, rom_addr);
        ram_rdata <= ram_mem[ram_raddr[7:0]];
        if (ram_wen) ram_mem[ram_waddr[7:0]] <= ram_wdata;
    end

    // Collect output handshakes, err pulses and busy cycles away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (out_valid && out_ready) begin
            outq.push_back({out_last, out_data});
            outcyc.push_back(cyc);
        end
        if (err) errcnt = errcnt + 1;
        if (busy) busycnt = busycnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a block of n words and stream words[0..n-1] in natural order.
    task automatic applyStimulus(input int n);
        int idx = 0;
        int guard = 0;
        logic hs;
        start   = 1'b1;
        blk_len = 16'(n);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = words[0];
        while (idx < n && guard < 100) begin
            @(negedge clk);
            hs = in_ready;
            tick();
            if (hs) idx++;
            if (idx < n) in_data = words[idx];
            guard++;
        end
        checkOutput("write_done", 32'(idx), 32'(n));
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic waitOutputs(input int n);
        for (int g = 0; g < 200; g++) begin
            @(posedge clk);
            if (outq.size() >= n) break;
        end
    endtask

    task automatic clearLog();
        outq.delete();
        outcyc.delete();
    endtask

    initial begin
        logic [13:0] exp_w;
        int gaps;
        int e0;
        for (int i = 0; i < 256; i++) ram_mem[i] = '0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ctrl", {in_ready, out_valid, out_last, ram_wen, busy, err}, 32'h0);
        checkOutput("rst_data", {out_data, ram_wdata}, 32'h0);
        checkOutput("rst_addr", {ram_waddr, ram_raddr}, 32'h0);
        checkOutput("rst_rom", rom_addr, 32'h0);

        // Identity ROM, N=4
        tick();
        clearLog();
        rom_mode = 0;
        words[0] = 13'd10; words[1] = 13'd11; words[2] = 13'd12; words[3] = 13'd13;
        applyStimulus(4);
        waitOutputs(4);
        @(negedge clk);
        checkOutput("id_busy_drop", busy, 0);
        checkOutput("id_count", outq.size(), 4);
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            exp_w = {(i == 3), 13'(10 + i)};
            checkOutput($sformatf("id_word%0d", i), outq[i], exp_w);
        end

        // Reverse ROM, N=8, full rate
        tick();
        clearLog();
        rom_mode = 1;
        for (int i = 0; i < 8; i++) words[i] = 13'(i);
        applyStimulus(8);
        waitOutputs(8);
        repeat (4) tick();
        checkOutput("rev_count", outq.size(), 8);
        for (int i = 0; i < 8 && i < outq.size(); i++) begin
            exp_w = {(i == 7), 13'(7 - i)};
            checkOutput($sformatf("rev_word%0d", i), outq[i], exp_w);
        end
        gaps = 0;
        for (int i = 1; i < outcyc.size(); i++) if (outcyc[i] - outcyc[i-1] != 1) gaps++;
        checkOutput("rev_rate_gaps", gaps, 0);

        // Reverse ROM, N=8, backpressure mid-read
        clearLog();
        for (int i = 0; i < 8; i++) words[i] = 13'(100 + i);
        applyStimulus(8);
        for (int g = 0; g < 50 && outq.size() < 2; g++) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        checkOutput("bp_held_valid", out_valid, 1);
        tick();
        out_ready = 1'b1;
        waitOutputs(8);
        repeat (6) tick();
        checkOutput("bp_count", outq.size(), 8);
        for (int i = 0; i < 8 && i < outq.size(); i++) begin
            exp_w = {(i == 7), 13'(107 - i)};
            checkOutput($sformatf("bp_word%0d", i), outq[i], exp_w);
        end

        // Zero-length start is rejected
        e0 = errcnt;
        busycnt = 0;
        start = 1'b1;
        blk_len = '0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        checkOutput("zero_err_pulses", errcnt - e0, 1);
        checkOutput("zero_busy_cycles", busycnt, 0);

        // Start while busy is ignored
        clearLog();
        rom_mode = 0;
        words[0] = 13'd55; words[1] = 13'd66;
        applyStimulus(2);
        e0 = errcnt;
        start = 1'b1;
        blk_len = 16'd5;
        tick();
        start = 1'b0;
        waitOutputs(2);
        repeat (10) tick();
        @(negedge clk);
        checkOutput("busy_start_idle", busy, 0);
        checkOutput("busy_start_count", outq.size(), 2);
        checkOutput("busy_start_err", errcnt - e0, 0);

        // Reset during READ, then a fresh N=2 block
        rom_mode = 1;
        for (int i = 0; i < 8; i++) words[i] = 13'(40 + i);
        applyStimulus(8);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ctrl", {in_ready, out_valid, out_last, ram_wen, busy, err}, 32'h0);
        checkOutput("midrst_data", {out_data, ram_wdata}, 32'h0);
        checkOutput("midrst_addr", {ram_waddr, ram_raddr}, 32'h0);
        checkOutput("midrst_rom", rom_addr, 32'h0);
        tick();
        clearLog();
        rom_mode = 0;
        words[0] = 13'd200; words[1] = 13'd300;
        applyStimulus(2);
        waitOutputs(2);
        repeat (3) tick();
        checkOutput("fresh_count", outq.size(), 2);
        if (outq.size() >= 2) begin
            checkOutput("fresh_word0", outq[0], {1'b0, 13'd200});
            checkOutput("fresh_word1", outq[1], {1'b1, 13'd300});
        end

`ifdef TURBO_ITL_RANGE_CHK_EN
        // Out-of-range ROM entry reads RAM word 0 and pulses err
        clearLog();
        rom_mode = 2;
        for (int i = 0; i < 8; i++) words[i] = 13'(20 + i);
        e0 = errcnt;
        applyStimulus(8);
        waitOutputs(8);
        repeat (4) tick();
        checkOutput("rng_err", errcnt - e0, 1);
        checkOutput("rng_count", outq.size(), 8);
        if (outq.size() >= 8) begin
            checkOutput("rng_fault_word", outq[3], {1'b0, 13'd20});
            checkOutput("rng_last_word", outq[7], {1'b1, 13'd20});
            checkOutput("rng_word0", outq[0], {1'b0, 13'd27});
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
